// File: rtl/alu_arbiter.sv
// Two-requester arbiter sharing one ALU: accept -> EXEC -> HOLD response handshake.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.

module alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  ALUOp,
  output logic [31:0] out
);
  logic signed [31:0] w_sa;
  logic signed [31:0] w_sb;

  assign w_sa = a;
  assign w_sb = b;

  always_comb begin
    out = '0;
    case (ALUOp)
      4'd0:    out = a & b;
      4'd1:    out = a | b;
      4'd2:    out = a + b;
      4'd3:    out = a - b;
      4'd4:    out = a ^ b;
      4'd5:    out = a << b[4:0];
      4'd6:    out = a >> b[4:0];
      4'd7:    out = w_sa >>> b[4:0];
      4'd8:    out = {31'd0, (w_sa < w_sb)};
      4'd9:    out = {31'd0, (a < b)};
      default: out = '0;
    endcase
  end
endmodule

module alu_arbiter #(
  parameter int unsigned MAX_OP = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req0_op,
  input  logic [3:0]  req1_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy
);
  localparam logic [3:0] MAX_OP_L = MAX_OP[3:0];

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_gnt;
  logic        w_accept;
  logic        w_rdy0;
  logic        w_rdy1;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [3:0]  r_op;
  logic        r_id;
  logic        r_valid;
  logic        r_rid;
  logic [31:0] r_data;
  logic        r_err;
  logic [31:0] w_alu_out;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign w_gnt = ~req0_valid & req1_valid;
`else
  // r_last holds the index granted on the previous accept; reset to 1 so requester 0 wins first
  logic r_last;

  assign w_gnt = (req0_valid & req1_valid) ? ~r_last : req1_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_last <= 1'b1;
    else if (w_accept) r_last <= w_gnt;
  end
`endif

  assign w_rdy0   = (r_state == IDLE) & ~rst & req0_valid & ~w_gnt;
  assign w_rdy1   = (r_state == IDLE) & ~rst & req1_valid &  w_gnt;
  assign w_accept = w_rdy0 | w_rdy1;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = EXEC;
      EXEC:    w_next = HOLD;
      HOLD:    if (r_valid && rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Operand latch: operand values are only meaningful once r_state leaves IDLE
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a  <= w_gnt ? req1_a  : req0_a;
      r_b  <= w_gnt ? req1_b  : req0_b;
      r_op <= w_gnt ? req1_op : req0_op;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_id <= 1'b0;
    else if (w_accept) r_id <= w_gnt;
  end

  alu u_alu (
    .a     (r_a),
    .b     (r_b),
    .ALUOp (r_op),
    .out   (w_alu_out)
  );

  // Response register: loaded at the end of EXEC, frozen through HOLD
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_rid   <= 1'b0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else if (r_state == EXEC) begin
      r_valid <= 1'b1;
      r_rid   <= r_id;
      r_err   <= (r_op > MAX_OP_L);
      r_data  <= (r_op > MAX_OP_L) ? 32'd0 : w_alu_out;
    end else if (r_state == HOLD && rsp_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign req0_ready = w_rdy0;
  assign req1_ready = w_rdy1;
  assign rsp_valid  = r_valid;
  assign rsp_id     = r_rid;
  assign rsp_data   = r_data;
  assign rsp_err    = r_err;
  assign busy       = (r_state != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: reset, arbitration, ALU ops, backpressure, error op, mid-flight reset.

module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [31:0] rsp_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.MAX_OP(9)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one transaction from IDLE with inputs already driven; holds rsp_ready low for hold_cycles in HOLD.
  task automatic txn(input string tag, input logic exp_id, input logic [31:0] exp_data,
                     input logic exp_err, input int hold_cycles);
    rsp_ready = (hold_cycles == 0);
    #1;
    chk({tag, ".rdy0"}, {31'd0, req0_ready}, {31'd0, ~exp_id});
    chk({tag, ".rdy1"}, {31'd0, req1_ready}, {31'd0, exp_id});
    chk({tag, ".idle_busy"}, {31'd0, busy}, 32'd0);
    step();
    chk({tag, ".exec_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, ".exec_nvld"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, ".exec_rdy"}, {30'd0, req0_ready, req1_ready}, 32'd0);
    step();
    for (int i = 0; i <= hold_cycles; i++) begin
      if (i == hold_cycles) rsp_ready = 1'b1;
      chk({tag, ".vld"}, {31'd0, rsp_valid}, 32'd1);
      chk({tag, ".id"}, {31'd0, rsp_id}, {31'd0, exp_id});
      chk({tag, ".data"}, rsp_data, exp_data);
      chk({tag, ".err"}, {31'd0, rsp_err}, {31'd0, exp_err});
      chk({tag, ".hold_busy"}, {31'd0, busy}, 32'd1);
      chk({tag, ".hold_rdy"}, {30'd0, req0_ready, req1_ready}, 32'd0);
      step();
    end
    chk({tag, ".done_vld"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, ".done_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    req0_op = 0; req1_op = 0;
    rsp_ready = 1'b0;
    step();
    step();
    chk("rst.vld",  {31'd0, rsp_valid}, 32'd0);
    chk("rst.id",   {31'd0, rsp_id}, 32'd0);
    chk("rst.data", rsp_data, 32'd0);
    chk("rst.err",  {31'd0, rsp_err}, 32'd0);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.rdy",  {30'd0, req0_ready, req1_ready}, 32'd0);
    rst = 1'b0;
    req1_valid = 1'b0;

    // single requester 0 add
    req0_a = 5; req0_b = 2; req0_op = 2;
    txn("add", 1'b0, 32'd7, 1'b0, 0);

    // contention from fresh reset: 0 sub, 1 xor
    reset_pulse();
    req0_valid = 1'b1; req0_a = 5; req0_b = 2; req0_op = 3;
    req1_valid = 1'b1; req1_a = 5; req1_b = 2; req1_op = 4;
`ifdef ALU_ARB_FIXED_PRIO_EN
    txn("rr1", 1'b0, 32'd3, 1'b0, 0);
    txn("rr2", 1'b0, 32'd3, 1'b0, 0);
    txn("rr3", 1'b0, 32'd3, 1'b0, 0);
`else
    txn("rr1", 1'b0, 32'd3, 1'b0, 0);
    txn("rr2", 1'b1, 32'd7, 1'b0, 0);
    txn("rr3", 1'b0, 32'd3, 1'b0, 0);
`endif

    // shifts and compares on requester 1 alone
    req0_valid = 1'b0;
    req1_a = 32'h8000_0000; req1_b = 4; req1_op = 7;
    txn("sra", 1'b1, 32'hF800_0000, 1'b0, 0);
    req1_op = 6;
    txn("srl", 1'b1, 32'h0800_0000, 1'b0, 0);
    req1_a = 32'hFFFF_FFFF; req1_b = 1; req1_op = 8;
    txn("slt", 1'b1, 32'd1, 1'b0, 0);
    req1_op = 9;
    txn("sltu", 1'b1, 32'd0, 1'b0, 0);
    req1_a = 32'h0000_0001; req1_b = 32'd35; req1_op = 5;
    txn("sll", 1'b1, 32'h0000_0008, 1'b0, 0);

    // backpressure: response must hold for 5 cycles
    req1_valid = 1'b0; req0_valid = 1'b1;
    req0_a = 5; req0_b = 2; req0_op = 2;
    txn("hold", 1'b0, 32'd7, 1'b0, 5);

    // illegal op, then and/or
    req0_op = 12;
    txn("bad", 1'b0, 32'd0, 1'b1, 0);
    req0_op = 0;
    txn("and", 1'b0, 32'd0, 1'b0, 0);
    req0_op = 1;
    txn("or", 1'b0, 32'd7, 1'b0, 0);

    // reset during EXEC of a requester-1 add
    req0_valid = 1'b0; req1_valid = 1'b1;
    req1_a = 10; req1_b = 20; req1_op = 2;
    #1;
    chk("abort.rdy1", {31'd0, req1_ready}, 32'd1);
    step();
    req1_valid = 1'b0;
    chk("abort.exec", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort.busy", {31'd0, busy}, 32'd0);
    step();
    rst = 1'b0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("abort.novld", {31'd0, rsp_valid}, 32'd0);
      step();
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 1; req0_b = 1; req0_op = 2;
    txn("post", 1'b0, 32'd2, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
